// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: requester, arbiter and memory-side signals of the shared word port
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              ReqI;
  logic [ADDR_W-1:0] AddrI;
  logic              ReqD;
  logic              WeD;
  logic [ADDR_W-1:0] AddrD;
  logic [DATA_W-1:0] WDataD;
  logic              GntI;
  logic              GntD;
  logic              DoneI;
  logic              DoneD;
  logic              ErrMis;
  logic [DATA_W-1:0] RData;
  logic [ADDR_W-1:0] MemAddr;
  logic [DATA_W-1:0] MemWData;
  logic              MemRead;
  logic              MemWrite;
  logic [DATA_W-1:0] MemRData;
  modport slave (
    input  ReqI, AddrI, ReqD, WeD, AddrD, WDataD, MemRData,
    output GntI, GntD, DoneI, DoneD, ErrMis, RData, MemAddr, MemWData, MemRead, MemWrite
  );
  modport master (
    output ReqI, AddrI, ReqD, WeD, AddrD, WDataD, MemRData,
    input  GntI, GntD, DoneI, DoneD, ErrMis, RData, MemAddr, MemWData, MemRead, MemWrite
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin sharing of a single-port word memory between fetch (I) and data (D) ports
module mem_port_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 1
) (
  input  logic Clk,
  input  logic Rst,
  mem_port_arbiter_if.slave bus
);
  localparam int CW = $clog2(WAIT_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t            state, state_nxt;
  logic              own_d, last_d, we, win_d, any_req, last_cyc, acc, dn;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata, rdata;
  logic [CW-1:0]     cnt;
  assign any_req  = bus.ReqI | bus.ReqD;
  assign win_d    = bus.ReqD & (~bus.ReqI | ~last_d);
  assign last_cyc = cnt == '0;
  assign bus.RData = rdata;
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state  <= IDLE;
      own_d  <= 1'b0;
      last_d <= 1'b1;
      we     <= 1'b0;
      addr   <= '0;
      wdata  <= '0;
      rdata  <= '0;
      cnt    <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && any_req) begin
        own_d  <= win_d;
        last_d <= win_d;
        we     <= win_d & bus.WeD;
        addr   <= win_d ? bus.AddrD : bus.AddrI;
        wdata  <= bus.WDataD;
        cnt    <= CW'(WAIT_CYCLES - 1);
      end else if (state == ACCESS) begin
        if (!last_cyc) cnt <= cnt - CW'(1);
        else if (!we) rdata <= bus.MemRData;
      end
    end
  end
  // Outputs are pure state decodes, forced low while Rst is held so a reset never lets a write through
  always_comb begin
    state_nxt    = state == IDLE   ? (any_req ? ACCESS : IDLE)
                 : state == ACCESS ? (last_cyc ? DONE : ACCESS)
                 : IDLE;
    acc          = !Rst && state == ACCESS;
    dn           = !Rst && state == DONE;
    bus.GntI     = (acc | dn) & ~own_d;
    bus.GntD     = (acc | dn) & own_d;
    bus.DoneI    = dn & ~own_d;
    bus.DoneD    = dn & own_d;
    bus.ErrMis   = dn & (addr[1:0] != 2'b00);
    bus.MemAddr  = acc ? {addr[ADDR_W-1:2], 2'b00} : '0;
    bus.MemWData = (acc & own_d) ? wdata : '0;
    bus.MemRead  = acc & ~we;
    bus.MemWrite = acc & we & last_cyc;
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: random requesters on a 1-wait and a 3-wait arbiter, checked every cycle against a latency model
module tb_mem_port_arbiter;
  localparam int N = 2000;
  logic clk = 1'b0;
  int passed = 0;
  int total = 0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
    else passed++;
  endtask
  for (genvar g = 0; g < 2; g++) begin : ch
    localparam int W = g ? 3 : 1;
    mem_port_arbiter_if b();
    logic rst;
    logic [31:0] mem [16];
    mem_port_arbiter #(.WAIT_CYCLES(W)) dut (.Clk(clk), .Rst(rst), .bus(b));
    assign b.MemRData = mem[b.MemAddr[5:2]];
    always @(posedge clk) if (b.MemWrite) mem[b.MemAddr[5:2]] <= b.MemWData;
    initial begin
      int age;
      bit own_d, last_d, we, acc, dn, dn_i, dn_d;
      logic [31:0] addr, wdata, rdata;
      logic [31:0] ref_mem [16];
      string p;
      p = W == 1 ? "w1." : "w3.";
      for (int i = 0; i < 16; i++) begin
        mem[i] = $urandom;
        ref_mem[i] = mem[i];
      end
      age = 0; own_d = 0; last_d = 1; we = 0; addr = 0; wdata = 0; rdata = 0; dn_i = 0; dn_d = 0;
      rst = 1; b.ReqI = 1; b.ReqD = 1; b.WeD = 0; b.AddrI = 32'h0C; b.AddrD = 32'h10; b.WDataD = 0;
      for (int c = 0; c < N; c++) begin
        if (c == 2) rst = 0;
        if (c >= 3) begin
          rst = $urandom_range(0, 63) == 0;
          if (dn_i) b.ReqI = $urandom_range(0, 3) == 0;
          else if (!b.ReqI) b.ReqI = $urandom_range(0, 1) == 1;
          else if ($urandom_range(0, 31) == 0) b.ReqI = 0;
          if (dn_d) b.ReqD = $urandom_range(0, 3) == 0;
          else if (!b.ReqD) b.ReqD = $urandom_range(0, 1) == 1;
          else if ($urandom_range(0, 31) == 0) b.ReqD = 0;
          if (!b.ReqI || $urandom_range(0, 7) == 0) b.AddrI = $urandom_range(0, 63);
          if (!b.ReqD || $urandom_range(0, 7) == 0) begin
            b.AddrD = $urandom_range(0, 63);
            b.WeD = $urandom_range(0, 1) == 1;
            b.WDataD = $urandom;
          end
        end
        @(posedge clk);
        if (rst) begin
          age = 0; last_d = 1; rdata = 0;
        end else if (age == 0) begin
          if (b.ReqI || b.ReqD) begin
            own_d = (b.ReqI && b.ReqD) ? !last_d : b.ReqD;
            last_d = own_d;
            addr = own_d ? b.AddrD : b.AddrI;
            we = own_d && b.WeD;
            wdata = b.WDataD;
            age = 1;
          end
        end else if (age == W + 1) age = 0;
        else begin
          if (age == W) begin
            if (we) ref_mem[addr[5:2]] = wdata;
            else rdata = ref_mem[addr[5:2]];
          end
          age++;
        end
        #1;
        acc = age >= 1 && age <= W;
        dn = age == W + 1;
        dn_i = dn && !own_d;
        dn_d = dn && own_d;
        chk({p, "GntI"}, b.GntI, (acc || dn) && !own_d);
        chk({p, "GntD"}, b.GntD, (acc || dn) && own_d);
        chk({p, "GntExcl"}, b.GntI & b.GntD, 0);
        chk({p, "DoneI"}, b.DoneI, dn_i);
        chk({p, "DoneD"}, b.DoneD, dn_d);
        chk({p, "ErrMis"}, b.ErrMis, dn && addr[1:0] != 0);
        chk({p, "RData"}, b.RData, rdata);
        chk({p, "MemAddr"}, b.MemAddr, acc ? {addr[31:2], 2'b00} : 0);
        chk({p, "MemWData"}, b.MemWData, (acc && own_d) ? wdata : 0);
        chk({p, "MemRead"}, b.MemRead, acc && !we);
        chk({p, "MemWrite"}, b.MemWrite, acc && we && age == W);
      end
    end
  end
  initial begin
    repeat (N + 5) @(posedge clk);
    #2;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
